// File: rtl/id_pipe_pkg.sv
// Shared RV32I decode definitions: opcode map, instruction type codes and
// the NOP encoding issued in place of bubbles and illegal instructions.
package id_pipe_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [6:0] INST_TYPE_LUI   = 7'b0110111;
    localparam logic [6:0] INST_TYPE_AUIPC = 7'b0010111;
    localparam logic [6:0] INST_TYPE_JAL   = 7'b1101111;
    localparam logic [6:0] INST_TYPE_JALR  = 7'b1100111;
    localparam logic [6:0] INST_TYPE_B     = 7'b1100011;
    localparam logic [6:0] INST_TYPE_L     = 7'b0000011;
    localparam logic [6:0] INST_TYPE_S     = 7'b0100011;
    localparam logic [6:0] INST_TYPE_I     = 7'b0010011;
    localparam logic [6:0] INST_TYPE_R     = 7'b0110011;

    localparam logic [6:0] NOP_OP     = 7'b0000001;
    localparam logic [2:0] NOP_FUNCT3 = 3'b000;
    localparam logic [6:0] NOP_FUNCT7 = 7'b0000000;

    localparam logic ReadEnable   = 1'b1;
    localparam logic ReadDisable  = 1'b0;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;

    localparam logic [XLEN_DEF-1:0] ZeroWord = '0;

    typedef enum logic [2:0] {
        RType, IType, SType, BType, UType, JType, InvType
    } inst_type_e;

    function automatic logic reads_rs1(input inst_type_e t);
        return (t inside {RType, IType, SType, BType}) ? ReadEnable : ReadDisable;
    endfunction

    function automatic logic reads_rs2(input inst_type_e t);
        return (t inside {RType, SType, BType}) ? ReadEnable : ReadDisable;
    endfunction

    function automatic logic writes_rd(input inst_type_e t);
        return (t inside {RType, IType, UType, JType}) ? WriteEnable : WriteDisable;
    endfunction

endpackage

// File: rtl/id_pipe_if.sv
// ID/EX issue bus: the registered decode bundle plus its valid/ready pair.
interface id_pipe_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
);
    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    pc_o;
    logic [6:0]         aluop_o;
    logic [2:0]         alufunct3_o;
    logic [6:0]         alufunct7_o;
    logic [XLEN-1:0]    reg1_o;
    logic [XLEN-1:0]    reg2_o;
    logic [XLEN-1:0]    imm_o;
    logic               wreg_o;
    logic [RADDR_W-1:0] wd_o;
    logic               illegal_o;

    modport master (
        output out_valid, pc_o, aluop_o, alufunct3_o, alufunct7_o,
               reg1_o, reg2_o, imm_o, wreg_o, wd_o, illegal_o,
        input  out_ready
    );

    modport slave (
        input  out_valid, pc_o, aluop_o, alufunct3_o, alufunct7_o,
               reg1_o, reg2_o, imm_o, wreg_o, wd_o, illegal_o,
        output out_ready
    );
endinterface

// File: rtl/id_imm_gen.sv
// Combinational instruction classification and sign-extended immediate
// generation for the RV32I base formats.
module id_imm_gen
    import id_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output inst_type_e      itype,
    output logic [XLEN-1:0] imm
);

    logic signed [11:0] imm_i_s;
    logic signed [11:0] imm_s_s;
    logic signed [12:0] imm_b_s;
    logic signed [31:0] imm_u_s;
    logic signed [20:0] imm_j_s;

    always_comb begin
        imm_i_s = inst[31:20];
        imm_s_s = {inst[31:25], inst[11:7]};
        imm_b_s = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        imm_u_s = {inst[31:12], 12'b0};
        imm_j_s = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

        itype = InvType;
        case (inst[6:0])
            INST_TYPE_LUI, INST_TYPE_AUIPC:          itype = UType;
            INST_TYPE_JAL:                           itype = JType;
            INST_TYPE_JALR, INST_TYPE_L, INST_TYPE_I: itype = IType;
            INST_TYPE_S:                             itype = SType;
            INST_TYPE_B:                             itype = BType;
            INST_TYPE_R:                             itype = RType;
            default:                                 itype = InvType;
        endcase

        imm = '0;
        case (itype)
            IType:   imm = XLEN'(imm_i_s);
            SType:   imm = XLEN'(imm_s_s);
            BType:   imm = XLEN'(imm_b_s);
            UType:   imm = XLEN'(imm_u_s);
            JType:   imm = XLEN'(imm_j_s);
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/id_pipe.sv
// RV32I decode stage with the ID/EX register folded in: operand forwarding,
// load-use interlock and valid/ready handshakes on both sides.
module id_pipe
    import id_pipe_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int RADDR_W      = 5,
    parameter int FWD_EN       = 1,
    parameter int ILLEGAL_TRAP = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    pc_i,
    input  logic [31:0]        inst_i,
    input  logic               flush_i,
    output logic               reg1_read_o,
    output logic               reg2_read_o,
    output logic [RADDR_W-1:0] reg1_addr_o,
    output logic [RADDR_W-1:0] reg2_addr_o,
    input  logic [XLEN-1:0]    reg1_data_i,
    input  logic [XLEN-1:0]    reg2_data_i,
    input  logic               ex_wreg_i,
    input  logic [RADDR_W-1:0] ex_wd_i,
    input  logic [XLEN-1:0]    ex_wdata_i,
    input  logic               ex_is_load_i,
    input  logic               mem_wreg_i,
    input  logic [RADDR_W-1:0] mem_wd_i,
    input  logic [XLEN-1:0]    mem_wdata_i,
    id_pipe_if.master          ex_bus
);

    function automatic logic [XLEN-1:0] sel_operand(
        input logic rd, input logic [RADDR_W-1:0] addr,
        input logic [XLEN-1:0] rf_data, input logic [XLEN-1:0] imm,
        input logic ex_wreg, input logic [RADDR_W-1:0] ex_wd, input logic [XLEN-1:0] ex_wdata,
        input logic mem_wreg, input logic [RADDR_W-1:0] mem_wd, input logic [XLEN-1:0] mem_wdata);
        if (!rd)                                    return imm;
        if (addr == '0)                             return '0;
        if (FWD_EN != 0 && ex_wreg && ex_wd == addr)   return ex_wdata;
        if (FWD_EN != 0 && mem_wreg && mem_wd == addr) return mem_wdata;
        return rf_data;
    endfunction

    // Without forwarding every in-flight writer of a source must drain first.
    function automatic logic hazard(
        input logic rd, input logic [RADDR_W-1:0] addr,
        input logic ex_wreg, input logic [RADDR_W-1:0] ex_wd, input logic ex_load,
        input logic mem_wreg, input logic [RADDR_W-1:0] mem_wd);
        if (!rd || addr == '0) return 1'b0;
        if (FWD_EN != 0)       return ex_load && ex_wreg && ex_wd == addr;
        return (ex_wreg && ex_wd == addr) || (mem_wreg && mem_wd == addr);
    endfunction

    inst_type_e         itype_p0;
    logic [XLEN-1:0]    imm_p0;
    logic [RADDR_W-1:0] wd_p0;
    logic [XLEN-1:0]    reg1_p0, reg2_p0;
    logic               illegal_p0, wreg_p0, stall_p0, accept_p0;

    logic               vld_p1, wreg_p1, illegal_p1;
    logic [XLEN-1:0]    pc_p1, reg1_p1, reg2_p1, imm_p1;
    logic [6:0]         aluop_p1, funct7_p1;
    logic [2:0]         funct3_p1;
    logic [RADDR_W-1:0] wd_p1;

    id_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst  (inst_i),
        .itype (itype_p0),
        .imm   (imm_p0)
    );

    // Stage p0: decode, operand resolution and interlock
    always_comb begin
        reg1_read_o = reads_rs1(itype_p0);
        reg2_read_o = reads_rs2(itype_p0);
        reg1_addr_o = RADDR_W'(inst_i[19:15]);
        reg2_addr_o = RADDR_W'(inst_i[24:20]);
        wd_p0       = RADDR_W'(inst_i[11:7]);
        illegal_p0  = (ILLEGAL_TRAP != 0) && (itype_p0 == InvType);
        wreg_p0     = writes_rd(itype_p0) && !illegal_p0 && (wd_p0 != '0);

        reg1_p0 = sel_operand(reg1_read_o, reg1_addr_o, reg1_data_i, imm_p0,
                              ex_wreg_i, ex_wd_i, ex_wdata_i, mem_wreg_i, mem_wd_i, mem_wdata_i);
        reg2_p0 = sel_operand(reg2_read_o, reg2_addr_o, reg2_data_i, imm_p0,
                              ex_wreg_i, ex_wd_i, ex_wdata_i, mem_wreg_i, mem_wd_i, mem_wdata_i);

        stall_p0 = hazard(reg1_read_o, reg1_addr_o, ex_wreg_i, ex_wd_i, ex_is_load_i, mem_wreg_i, mem_wd_i)
                || hazard(reg2_read_o, reg2_addr_o, ex_wreg_i, ex_wd_i, ex_is_load_i, mem_wreg_i, mem_wd_i);

        in_ready  = !rst && !flush_i && !stall_p0 && (!vld_p1 || ex_bus.out_ready);
        accept_p0 = in_valid && in_ready;
    end

    // Stage p1: ID/EX register (flush kills, back-pressure holds, else load or bubble)
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            pc_p1      <= '0;
            aluop_p1   <= NOP_OP;
            funct3_p1  <= '0;
            funct7_p1  <= '0;
            reg1_p1    <= '0;
            reg2_p1    <= '0;
            imm_p1     <= '0;
            wreg_p1    <= WriteDisable;
            wd_p1      <= '0;
            illegal_p1 <= 1'b0;
        end else if (flush_i) begin
            vld_p1     <= 1'b0;
            wreg_p1    <= WriteDisable;
            illegal_p1 <= 1'b0;
        end else if (!vld_p1 || ex_bus.out_ready) begin
            if (accept_p0) begin
                vld_p1     <= 1'b1;
                pc_p1      <= pc_i;
                aluop_p1   <= illegal_p0 ? NOP_OP : inst_i[6:0];
                funct3_p1  <= illegal_p0 ? NOP_FUNCT3 : inst_i[14:12];
                funct7_p1  <= illegal_p0 ? NOP_FUNCT7 : inst_i[31:25];
                reg1_p1    <= reg1_p0;
                reg2_p1    <= reg2_p0;
                imm_p1     <= imm_p0;
                wreg_p1    <= wreg_p0;
                wd_p1      <= wd_p0;
                illegal_p1 <= illegal_p0;
            end else begin
                vld_p1     <= 1'b0;
                wreg_p1    <= WriteDisable;
                illegal_p1 <= 1'b0;
            end
        end
    end

    assign ex_bus.out_valid   = vld_p1;
    assign ex_bus.pc_o        = pc_p1;
    assign ex_bus.aluop_o     = aluop_p1;
    assign ex_bus.alufunct3_o = funct3_p1;
    assign ex_bus.alufunct7_o = funct7_p1;
    assign ex_bus.reg1_o      = reg1_p1;
    assign ex_bus.reg2_o      = reg2_p1;
    assign ex_bus.imm_o       = imm_p1;
    assign ex_bus.wreg_o      = wreg_p1;
    assign ex_bus.wd_o        = wd_p1;
    assign ex_bus.illegal_o   = illegal_p1;

endmodule

// File: tb/tb_id_pipe.sv
// Directed and randomized bench for id_pipe against a behavioural decode model.
module tb_id_pipe;

    logic        clk, rst, in_valid, flush, ordy;
    logic [31:0] pc, inst, rd1_data, rd2_data;
    logic        ex_wreg, ex_load, mem_wreg;
    logic [4:0]  ex_wd, mem_wd;
    logic [31:0] ex_wdata, mem_wdata;
    wire         in_ready, r1_rd, r2_rd;
    wire  [4:0]  r1_addr, r2_addr;

    id_pipe_if #(.XLEN(32), .RADDR_W(5)) bus ();
    assign bus.out_ready = ordy;

    id_pipe #(.XLEN(32), .RADDR_W(5), .FWD_EN(1), .ILLEGAL_TRAP(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .pc_i(pc), .inst_i(inst), .flush_i(flush),
        .reg1_read_o(r1_rd), .reg2_read_o(r2_rd),
        .reg1_addr_o(r1_addr), .reg2_addr_o(r2_addr),
        .reg1_data_i(rd1_data), .reg2_data_i(rd2_data),
        .ex_wreg_i(ex_wreg), .ex_wd_i(ex_wd), .ex_wdata_i(ex_wdata), .ex_is_load_i(ex_load),
        .mem_wreg_i(mem_wreg), .mem_wd_i(mem_wd), .mem_wdata_i(mem_wdata),
        .ex_bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model of the ID/EX register contents
    logic        m_valid, m_illegal, m_wreg, m_data_known;
    logic [31:0] m_pc, m_reg1, m_reg2, m_imm;
    logic [6:0]  m_aluop, m_f7;
    logic [2:0]  m_f3;
    logic [4:0]  m_wd;

    localparam int K_R = 0, K_I = 1, K_S = 2, K_B = 3, K_U = 4, K_J = 5, K_ILL = 6;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic void decode(input logic [31:0] i, output int kind, output logic [31:0] imm);
        case (i[6:0])
            7'h37, 7'h17:        kind = K_U;
            7'h6F:               kind = K_J;
            7'h67, 7'h03, 7'h13: kind = K_I;
            7'h23:               kind = K_S;
            7'h63:               kind = K_B;
            7'h33:               kind = K_R;
            default:             kind = K_ILL;
        endcase
        case (kind)
            K_I: imm = {{20{i[31]}}, i[31:20]};
            K_S: imm = {{20{i[31]}}, i[31:25], i[11:7]};
            K_B: imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            K_U: imm = {i[31:12], 12'h000};
            K_J: imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: imm = 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] opnd(input logic rd, input logic [4:0] a,
                                         input logic [31:0] rf, input logic [31:0] imm);
        if (!rd) return imm;
        if (a == 5'd0) return 32'h0;
        if (ex_wreg && ex_wd == a) return ex_wdata;
        if (mem_wreg && mem_wd == a) return mem_wdata;
        return rf;
    endfunction

    // One clock: check combinational outputs, advance the model, check the register.
    task automatic cycle();
        int k;
        logic [31:0] imm;
        logic rd1, rd2, stall, exp_ready;
        @(negedge clk);
        decode(inst, k, imm);
        rd1 = (k == K_R || k == K_I || k == K_S || k == K_B);
        rd2 = (k == K_R || k == K_S || k == K_B);
        stall = (rd1 && inst[19:15] != 0 && ex_load && ex_wreg && ex_wd == inst[19:15]) ||
                (rd2 && inst[24:20] != 0 && ex_load && ex_wreg && ex_wd == inst[24:20]);
        exp_ready = !rst && !flush && !stall && (!m_valid || ordy);
        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
        chk("reg1_read", {31'b0, r1_rd}, {31'b0, rd1});
        chk("reg2_read", {31'b0, r2_rd}, {31'b0, rd2});
        chk("reg1_addr", {27'b0, r1_addr}, {27'b0, inst[19:15]});
        chk("reg2_addr", {27'b0, r2_addr}, {27'b0, inst[24:20]});

        if (rst) begin
            m_valid = 0; m_illegal = 0; m_wreg = 0; m_pc = 0; m_reg1 = 0; m_reg2 = 0;
            m_imm = 0; m_aluop = 7'h01; m_f3 = 0; m_f7 = 0; m_wd = 0; m_data_known = 1;
        end else if (flush) begin
            m_valid = 0; m_illegal = 0; m_wreg = 0; m_data_known = 0;
        end else if (m_valid && !ordy) begin
            // held
        end else if (in_valid && exp_ready) begin
            m_valid = 1;
            m_illegal = (k == K_ILL);
            m_pc = pc;
            m_imm = imm;
            m_wd = inst[11:7];
            m_aluop = m_illegal ? 7'h01 : inst[6:0];
            m_f3 = inst[14:12];
            m_f7 = inst[31:25];
            m_wreg = (k == K_R || k == K_I || k == K_U || k == K_J) && inst[11:7] != 0;
            m_reg1 = opnd(rd1, inst[19:15], rd1_data, imm);
            m_reg2 = opnd(rd2, inst[24:20], rd2_data, imm);
            m_data_known = 1;
        end else begin
            m_valid = 0; m_illegal = 0; m_wreg = 0; m_data_known = 0;
        end

        @(posedge clk);
        #1;
        chk("out_valid", {31'b0, bus.out_valid}, {31'b0, m_valid});
        chk("wreg_o", {31'b0, bus.wreg_o}, {31'b0, m_wreg});
        chk("illegal_o", {31'b0, bus.illegal_o}, {31'b0, m_illegal});
        if (m_data_known) begin
            chk("pc_o", bus.pc_o, m_pc);
            chk("aluop_o", {25'b0, bus.aluop_o}, {25'b0, m_aluop});
            chk("imm_o", bus.imm_o, m_imm);
            chk("wd_o", {27'b0, bus.wd_o}, {27'b0, m_wd});
            if (!m_illegal) begin
                chk("funct3_o", {29'b0, bus.alufunct3_o}, {29'b0, m_f3});
                chk("funct7_o", {25'b0, bus.alufunct7_o}, {25'b0, m_f7});
                chk("reg1_o", bus.reg1_o, m_reg1);
                chk("reg2_o", bus.reg2_o, m_reg2);
            end
        end
    endtask

    localparam logic [6:0] OPS [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03,
                                        7'h13, 7'h23, 7'h63, 7'h33, 7'h7F};

    initial begin
        logic [31:0] r;
        rst = 1; in_valid = 0; flush = 0; ordy = 1; pc = 0; inst = 32'h00000013;
        rd1_data = 32'h11111111; rd2_data = 32'h22222222;
        ex_wreg = 0; ex_load = 0; ex_wd = 0; ex_wdata = 0;
        mem_wreg = 0; mem_wd = 0; mem_wdata = 0;
        m_valid = 0; m_illegal = 0; m_wreg = 0; m_data_known = 0;
        m_pc = 0; m_reg1 = 0; m_reg2 = 0; m_imm = 0; m_aluop = 0; m_f3 = 0; m_f7 = 0; m_wd = 0;

        cycle(); cycle();
        chk("rst_aluop", {25'b0, bus.aluop_o}, 32'h1);
        chk("rst_reg1", bus.reg1_o, 32'h0);
        rst = 0;
        cycle();

        // addi x1,x0,5
        in_valid = 1; pc = 32'h100; inst = 32'h00500093;
        cycle();
        chk("addi_valid", {31'b0, bus.out_valid}, 32'h1);
        chk("addi_reg1", bus.reg1_o, 32'h0);
        chk("addi_reg2", bus.reg2_o, 32'h5);
        chk("addi_imm", bus.imm_o, 32'h5);
        chk("addi_wd", {27'b0, bus.wd_o}, 32'h1);
        chk("addi_wreg", {31'b0, bus.wreg_o}, 32'h1);

        // add x4,x3,x3 with EX and MEM both targeting x3
        pc = 32'h104; inst = 32'h00318233;
        ex_wreg = 1; ex_wd = 3; ex_wdata = 32'hDEADBEEF;
        mem_wreg = 1; mem_wd = 3; mem_wdata = 32'h1;
        cycle();
        chk("fwd_ex_r1", bus.reg1_o, 32'hDEADBEEF);
        chk("fwd_ex_r2", bus.reg2_o, 32'hDEADBEEF);
        ex_wreg = 0;
        cycle();
        chk("fwd_mem_r1", bus.reg1_o, 32'h1);
        chk("fwd_mem_r2", bus.reg2_o, 32'h1);

        // load-use interlock for one cycle
        ex_wreg = 1; ex_load = 1;
        cycle();
        chk("lu_ready", {31'b0, in_ready}, 32'h0);
        chk("lu_bubble", {31'b0, bus.out_valid}, 32'h0);
        ex_load = 0;
        cycle();
        chk("lu_resume", {31'b0, bus.out_valid}, 32'h1);
        chk("lu_fwd", bus.reg1_o, 32'hDEADBEEF);
        ex_wreg = 0; mem_wreg = 0;

        // back-pressure hold
        pc = 32'h200; inst = 32'h00500093;
        cycle();
        ordy = 0; pc = 32'h204; inst = 32'h123452B7;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("hold_valid", {31'b0, bus.out_valid}, 32'h1);
            chk("hold_pc", bus.pc_o, 32'h200);
            chk("hold_ready", {31'b0, in_ready}, 32'h0);
        end
        ordy = 1;
        cycle();
        chk("lui_imm", bus.imm_o, 32'h12345000);
        chk("lui_wd", {27'b0, bus.wd_o}, 32'h5);

        // flush while holding lui
        ordy = 0; in_valid = 0;
        cycle();
        flush = 1;
        cycle();
        chk("flush_valid", {31'b0, bus.out_valid}, 32'h0);
        flush = 0; ordy = 1;

        // illegal opcode
        in_valid = 1; pc = 32'h300; inst = 32'h0000007F;
        cycle();
        chk("ill_flag", {31'b0, bus.illegal_o}, 32'h1);
        chk("ill_wreg", {31'b0, bus.wreg_o}, 32'h0);
        chk("ill_valid", {31'b0, bus.out_valid}, 32'h1);

        // reset during a stall
        inst = 32'h00318233; ex_wreg = 1; ex_load = 1; ex_wd = 3; ordy = 0;
        cycle();
        rst = 1;
        cycle();
        chk("rst_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("rst_pc", bus.pc_o, 32'h0);
        rst = 0; ex_wreg = 0; ex_load = 0; ordy = 1; in_valid = 0;
        #1;
        chk("post_rst_ready", {31'b0, in_ready}, 32'h1);
        cycle();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            r = $urandom();
            inst = {r[31:7], OPS[$urandom_range(0, 9)]};
            inst[19:15] = 5'($urandom_range(0, 3));
            inst[24:20] = 5'($urandom_range(0, 3));
            inst[11:7]  = 5'($urandom_range(0, 3));
            pc = $urandom();
            in_valid = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 15) == 0);
            rd1_data = $urandom(); rd2_data = $urandom();
            ex_wreg = $urandom_range(0, 1); ex_load = ($urandom_range(0, 3) == 0);
            ex_wd = 5'($urandom_range(0, 3)); ex_wdata = $urandom();
            mem_wreg = $urandom_range(0, 1);
            mem_wd = 5'($urandom_range(0, 3)); mem_wdata = $urandom();
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
